// File: rtl/hpsdr_proto_pkg.sv
// Shared HPSDR old-protocol constants, state encoding and header helper.
// Used by tx_send (optional macro TX_REQ_TIMEOUT_EN) and tx_disc_rom.
package hpsdr_proto_pkg;

  localparam logic [7:0] PREAMBLE0     = 8'hEF;
  localparam logic [7:0] PREAMBLE1     = 8'hFE;
  localparam logic [7:0] CMD_DATA      = 8'h01;
  localparam logic [7:0] CMD_DISC_IDLE = 8'h02;
  localparam logic [7:0] CMD_DISC_RUN  = 8'h03;
  localparam logic [7:0] CMD_PROGRAM   = 8'h04;
  localparam logic [7:0] EP6           = 8'h06;

  localparam logic [10:0] DATA_FRAME_LEN = 11'd1032;
  localparam logic [10:0] DISC_FRAME_LEN = 11'd60;
  localparam logic [10:0] IQ_PAYLOAD_LEN = 11'd1024;
  localparam logic [10:0] HEADER_LEN     = 11'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HEADER,
    S_DATA,
    S_DISC
  } state_t;

  typedef enum logic {
    K_DATA,
    K_DISC
  } kind_t;

  function automatic logic [7:0] hdr_byte(
    input logic [2:0]  idx,
    input logic [31:0] seq
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = PREAMBLE0;
      3'd1:    b = PREAMBLE1;
      3'd2:    b = CMD_DATA;
      3'd3:    b = EP6;
      3'd4:    b = seq[31:24];
      3'd5:    b = seq[23:16];
      3'd6:    b = seq[15:8];
      default: b = seq[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tx_disc_rom.sv
// Combinational byte mux for the 60-byte Metis discovery reply.
// Byte index comes from the frame byte counter of tx_send.
module tx_disc_rom
  import hpsdr_proto_pkg::*;
#(
  parameter logic [7:0] CODE_VERSION = 8'd30,
  parameter logic [7:0] BOARD_ID     = 8'h06
) (
  input  logic [10:0] idx,
  input  logic [47:0] mac,
  input  logic        run_latched,
  output logic [7:0]  data
);

  always_comb begin
    data = 8'h00;
    case (idx)
      11'd0:   data = PREAMBLE0;
      11'd1:   data = PREAMBLE1;
      11'd2:   data = run_latched ? CMD_DISC_RUN
                                  : CMD_DISC_IDLE;
      11'd3:   data = mac[47:40];
      11'd4:   data = mac[39:32];
      11'd5:   data = mac[31:24];
      11'd6:   data = mac[23:16];
      11'd7:   data = mac[15:8];
      11'd8:   data = mac[7:0];
      11'd9:   data = CODE_VERSION;
      11'd10:  data = BOARD_ID;
      default: data = 8'h00;
    endcase
  end

endmodule

// File: rtl/tx_send.sv
// Builds EP6 IQ frames and discovery replies for the UDP transmitter.
// Optional macro TX_REQ_TIMEOUT_EN adds a grant timeout in REQ.
module tx_send
  import hpsdr_proto_pkg::*;
#(
  parameter logic [7:0]  CODE_VERSION = 8'd30,
  parameter logic [7:0]  BOARD_ID     = 8'h06,
  parameter logic [15:0] REQ_TIMEOUT  = 16'd50000
) (
  input  logic        tx_clk,
  input  logic        reset,
  input  logic        run,
  input  logic        discovery_reply,
  input  logic [47:0] mac,
  input  logic [11:0] tx_fifo_count,
  input  logic [7:0]  tx_fifo_data,
  output logic        tx_fifo_rdreq,
  output logic        udp_tx_request,
  output logic [10:0] udp_tx_length,
  input  logic        udp_tx_enable,
  output logic [7:0]  udp_tx_data
);

  state_t      state;
  kind_t       kind;
  logic [10:0] byte_cnt;
  logic [31:0] seq;
  logic        seq_clr;
  logic        disc_pending;
  logic        run_q;
  logic        run_latched;
  logic [7:0]  disc_byte;

  logic disc_req;
  logic run_rise;
  logic data_busy;
  logic data_end;
  logic fifo_ready;
  logic req_expire;

  assign disc_req   = disc_pending | discovery_reply;
  assign run_rise   = run & ~run_q;
  assign data_busy  = (kind == K_DATA) && (state != S_IDLE);
  assign fifo_ready = tx_fifo_count >= {1'b0, IQ_PAYLOAD_LEN};
  assign data_end   = (state == S_DATA) && udp_tx_enable &&
                      (byte_cnt == DATA_FRAME_LEN - 11'd1);

`ifdef TX_REQ_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign req_expire = (state == S_REQ) && !udp_tx_enable &&
                      (tmo_cnt == REQ_TIMEOUT - 16'd1);

  always_ff @(posedge tx_clk) begin
    if (reset || state != S_REQ)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 16'd1;
  end
`else
  assign req_expire = 1'b0;
`endif

  tx_disc_rom #(
    .CODE_VERSION (CODE_VERSION),
    .BOARD_ID     (BOARD_ID)
  ) u_rom (
    .idx         (byte_cnt),
    .mac         (mac),
    .run_latched (run_latched),
    .data        (disc_byte)
  );

  always_ff @(posedge tx_clk) begin
    if (reset) begin
      state          <= S_IDLE;
      kind           <= K_DATA;
      byte_cnt       <= '0;
      seq            <= '0;
      seq_clr        <= 1'b0;
      disc_pending   <= 1'b0;
      run_q          <= 1'b0;
      run_latched    <= 1'b0;
      udp_tx_request <= 1'b0;
      udp_tx_length  <= '0;
    end else begin
      run_q <= run;

      if (data_end) begin
        seq     <= (seq_clr | run_rise) ? '0 : seq + 32'd1;
        seq_clr <= 1'b0;
      end else if (!data_busy) begin
        if (seq_clr | run_rise)
          seq <= '0;
        seq_clr <= 1'b0;
      end else if (run_rise) begin
        seq_clr <= 1'b1;
      end

      if (state == S_REQ && kind == K_DISC &&
          (udp_tx_enable || req_expire))
        disc_pending <= 1'b0;
      if (discovery_reply)
        disc_pending <= 1'b1;

      unique case (state)
        S_IDLE: begin
          byte_cnt <= '0;
          if (disc_req) begin
            state          <= S_REQ;
            kind           <= K_DISC;
            run_latched    <= run;
            udp_tx_request <= 1'b1;
            udp_tx_length  <= DISC_FRAME_LEN;
          end else if (run && fifo_ready) begin
            state          <= S_REQ;
            kind           <= K_DATA;
            udp_tx_request <= 1'b1;
            udp_tx_length  <= DATA_FRAME_LEN;
          end
        end
        S_REQ: begin
          if (udp_tx_enable) begin
            udp_tx_request <= 1'b0;
            udp_tx_length  <= '0;
            byte_cnt       <= 11'd1;
            state          <= (kind == K_DATA) ? S_HEADER : S_DISC;
          end else if (req_expire) begin
            udp_tx_request <= 1'b0;
            udp_tx_length  <= '0;
            state          <= S_IDLE;
          end
        end
        S_HEADER: begin
          if (udp_tx_enable) begin
            byte_cnt <= byte_cnt + 11'd1;
            if (byte_cnt == HEADER_LEN - 11'd1)
              state <= S_DATA;
          end
        end
        S_DATA: begin
          if (udp_tx_enable) begin
            byte_cnt <= byte_cnt + 11'd1;
            if (data_end)
              state <= S_IDLE;
          end
        end
        S_DISC: begin
          if (udp_tx_enable) begin
            byte_cnt <= byte_cnt + 11'd1;
            if (byte_cnt == DISC_FRAME_LEN - 11'd1)
              state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign tx_fifo_rdreq = (state == S_DATA) && udp_tx_enable;

  always_comb begin
    udp_tx_data = 8'h00;
    unique case (1'b1)
      state == S_REQ:
        udp_tx_data = (kind == K_DISC) ? disc_byte
                                       : hdr_byte(3'd0, seq);
      state == S_HEADER:
        udp_tx_data = hdr_byte(byte_cnt[2:0], seq);
      state == S_DATA:
        udp_tx_data = tx_fifo_data;
      state == S_DISC:
        udp_tx_data = disc_byte;
      default: ;
    endcase
  end

endmodule
